// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared command codes, scan codes and parser states for the PS/2 key command block
package ps2_pkg;

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_LEFT   = 3'd1;
    localparam logic [2:0] CMD_RIGHT  = 3'd2;
    localparam logic [2:0] CMD_DOWN   = 3'd3;
    localparam logic [2:0] CMD_ROTATE = 3'd4;
    localparam logic [2:0] CMD_DROP   = 3'd5;
    localparam logic [2:0] CMD_PAUSE  = 3'd6;

    localparam logic [7:0] SC_NULL  = 8'h00;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_E1    = 8'hE1;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_P     = 8'h4D;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_t;

    // Arrow keys live in the extended page, action keys in the base page.
    function automatic logic [2:0] map_key(input logic ext, input logic [7:0] code);
        logic [2:0] c;
        c = CMD_NONE;
        if (ext) begin
            case (code)
                SC_LEFT:  c = CMD_LEFT;
                SC_RIGHT: c = CMD_RIGHT;
                SC_DOWN:  c = CMD_DOWN;
                SC_UP:    c = CMD_ROTATE;
                default:  c = CMD_NONE;
            endcase
        end else begin
            case (code)
                SC_SPACE: c = CMD_DROP;
                SC_P:     c = CMD_PAUSE;
                default:  c = CMD_NONE;
            endcase
        end
        return c;
    endfunction

    // Bit positions in key_held: {rotate, down, right, left}.
    function automatic logic [3:0] held_mask(input logic [2:0] c);
        logic [3:0] m;
        case (c)
            CMD_LEFT:   m = 4'b0001;
            CMD_RIGHT:  m = 4'b0010;
            CMD_DOWN:   m = 4'b0100;
            CMD_ROTATE: m = 4'b1000;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic is_repeatable(input logic [2:0] c);
        return (c == CMD_LEFT) || (c == CMD_RIGHT) || (c == CMD_DOWN);
    endfunction

endpackage

// File: rtl/ps2_cmd_fifo.sv
// rtl/ps2_cmd_fifo.sv - small command queue with simultaneous push/pop when full
module ps2_cmd_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 3
) (
    input  logic                          inclock,
    input  logic                          resetn,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset because the read path masks an empty queue.
    always_ff @(posedge inclock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge inclock) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_cmd_ctrl.sv
// rtl/ps2_key_cmd_ctrl.sv - PS/2 scan-code parser and key map feeding a game command queue (optional PS2_AUTOREPEAT_EN)
module ps2_key_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int REPEAT_DELAY  = 15000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       inclock,
    input  logic       resetn,
    input  logic [7:0] key_data,
    input  logic       key_valid,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [3:0] key_held,
    output logic       overflow
);
    ps2_state_t state;
    ps2_state_t state_next;
    logic       make_ev;
    logic       brk_ev;
    logic       ev_ext;
    logic [2:0] ev_cmd;
    logic [3:0] ev_mask;
    logic       dec_push;
    logic       rep_push;
    logic       push;
    logic [2:0] push_data;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] unused_count;

    // Parser state register.
    always_ff @(posedge inclock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Prefix tracking and make/break event generation.
    always_comb begin
        state_next = state;
        make_ev    = 1'b0;
        brk_ev     = 1'b0;
        ev_ext     = 1'b0;
        if (key_valid) begin
            case (state)
                IDLE: begin
                    if (key_data == SC_EXT)      state_next = EXT;
                    else if (key_data == SC_BRK) state_next = BRK;
                    else if (key_data != SC_NULL && key_data != SC_E1) make_ev = 1'b1;
                end
                EXT: begin
                    if (key_data == SC_BRK) begin
                        state_next = EXT_BRK;
                    end else begin
                        make_ev    = 1'b1;
                        ev_ext     = 1'b1;
                        state_next = IDLE;
                    end
                end
                BRK: begin
                    brk_ev     = 1'b1;
                    state_next = IDLE;
                end
                EXT_BRK: begin
                    brk_ev     = 1'b1;
                    ev_ext     = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign ev_cmd  = map_key(ev_ext, key_data);
    assign ev_mask = held_mask(ev_cmd);

`ifdef PS2_AUTOREPEAT_EN
    // Keyboard typematic makes are dropped; the local repeat timer paces repeats instead.
    assign dec_push = make_ev && (ev_cmd != CMD_NONE) && ((key_held & ev_mask) == 4'b0000);
`else
    assign dec_push = make_ev && (ev_cmd != CMD_NONE);
`endif

    // Live held state follows make/break of the four movement keys.
    always_ff @(posedge inclock) begin
        if (!resetn)      key_held <= 4'b0000;
        else if (make_ev) key_held <= key_held | ev_mask;
        else if (brk_ev)  key_held <= key_held & ~ev_mask;
    end

`ifdef PS2_AUTOREPEAT_EN
    logic        rep_armed;
    logic        rep_first;
    logic [2:0]  rep_cmd;
    logic [31:0] rep_timer;
    logic [31:0] rep_limit;

    assign rep_limit = rep_first ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_PERIOD - 1);
    assign rep_push  = rep_armed && (rep_timer == rep_limit);

    // Repeat timer: arm/retarget on a repeatable make, stop on its break, hold at terminal count if pre-empted.
    always_ff @(posedge inclock) begin
        if (!resetn) begin
            rep_armed <= 1'b0;
            rep_first <= 1'b0;
            rep_cmd   <= CMD_NONE;
            rep_timer <= '0;
        end else if (dec_push && is_repeatable(ev_cmd)) begin
            rep_armed <= 1'b1;
            rep_first <= 1'b1;
            rep_cmd   <= ev_cmd;
            rep_timer <= '0;
        end else if (brk_ev && rep_armed && (ev_cmd == rep_cmd)) begin
            rep_armed <= 1'b0;
            rep_timer <= '0;
        end else if (rep_push && !dec_push) begin
            rep_first <= 1'b0;
            rep_timer <= '0;
        end else if (rep_armed && !rep_push) begin
            rep_timer <= rep_timer + 32'd1;
        end
    end

    assign push_data = dec_push ? ev_cmd : rep_cmd;
`else
    logic unused_cfg;
    assign unused_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign rep_push   = 1'b0;
    assign push_data  = ev_cmd;
`endif

    assign push = dec_push || rep_push;
    assign pop  = cmd_valid && cmd_ready;

    ps2_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (3)
    ) u_fifo (
        .inclock   (inclock),
        .resetn    (resetn),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (cmd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (unused_count)
    );

    assign cmd_valid = !fifo_empty;

    // Sticky drop flag: a push that found the queue full with no head leaving.
    always_ff @(posedge inclock) begin
        if (!resetn)                           overflow <= 1'b0;
        else if (push && fifo_full && !pop)    overflow <= 1'b1;
    end

endmodule
